// File: rtl/hex_undump_if.sv
// Character-in / byte-out bundle for hex_undump.
// Master drives characters and read strobes; slave returns the FIFO head and status.
// No backpressure on the character side; the read side is show-ahead with a pop strobe.
interface hex_undump_if #(
  parameter int ADDR_BITS = 4
);
  logic [7:0]         in_data;
  logic               in_strobe;
  logic [7:0]         out_data;
  logic               out_available;
  logic               out_read_strobe;
  logic [ADDR_BITS:0] out_count;
  logic               err_strobe;
  logic               overflow;

  modport master (
    output in_data, in_strobe, out_read_strobe,
    input  out_data, out_available, out_count, err_strobe, overflow
  );

  modport slave (
    input  in_data, in_strobe, out_read_strobe,
    output out_data, out_available, out_count, err_strobe, overflow
  );
endinterface

// File: rtl/hex_undump.sv
// Pairs ASCII hex digits into bytes and queues them in a show-ahead FIFO.
// Latency: second digit strobed in cycle N -> byte visible at the FIFO head in cycle N+1.
// No input backpressure: a byte decoded while the FIFO is full (and not popped) is dropped and flagged sticky.
module hex_undump #(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  hex_undump_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_t;

  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);

  state_t               state, state_next;
  logic [3:0]           hi, hi_next;
  logic [3:0]           nibble;
  logic                 is_hex, is_sep;
  logic                 push, err_next;
  logic                 pop, do_push, full;
  logic [7:0]           mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [ADDR_BITS:0]   count;
  logic                 err_q, overflow_q;

  // Classify the incoming character and extract its nibble value.
  always_comb begin
    is_hex = 1'b0;
    is_sep = 1'b0;
    nibble = 4'h0;
    if (bus.in_data >= 8'h30 && bus.in_data <= 8'h39) begin
      is_hex = 1'b1;
      nibble = bus.in_data[3:0];
    end else if ((bus.in_data >= 8'h61 && bus.in_data <= 8'h66) ||
                 (bus.in_data >= 8'h41 && bus.in_data <= 8'h46)) begin
      is_hex = 1'b1;
      nibble = bus.in_data[3:0] + 4'd9;
    end else if (bus.in_data == 8'h20 || bus.in_data == 8'h09 ||
                 bus.in_data == 8'h0D || bus.in_data == 8'h0A) begin
      is_sep = 1'b1;
    end
  end

  // Digit-pairing decisions; only a strobed character moves the FSM.
  always_comb begin
    state_next = state;
    hi_next    = hi;
    push       = 1'b0;
    err_next   = 1'b0;
    if (bus.in_strobe) begin
      case (state)
        EMPTY: begin
          if (is_hex) begin
            hi_next    = nibble;
            state_next = HALF;
          end else if (!is_sep) begin
            err_next = 1'b1;
          end
        end
        HALF: begin
          state_next = EMPTY;
          if (is_hex) push = 1'b1;
          else        err_next = 1'b1;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // FSM state, pending high nibble and the registered error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      hi    <= 4'h0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      hi    <= hi_next;
      err_q <= err_next;
    end
  end

  // A pop while full frees the slot this edge, so a simultaneous push still fits.
  assign full    = (count == FULL_COUNT);
  assign pop     = bus.out_read_strobe && (count != '0);
  assign do_push = push && (!full || pop);

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_BITS'(1);
      if (pop)     rd_ptr <= rd_ptr + ADDR_BITS'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (ADDR_BITS + 1)'(1);
        2'b01:   count <= count - (ADDR_BITS + 1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {hi, nibble};
  end

  assign bus.out_data      = (count != '0) ? mem[rd_ptr] : 8'h00;
  assign bus.out_available = (count != '0);
  assign bus.out_count     = count;
  assign bus.err_strobe    = err_q;
  assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_hex_undump.sv
// Randomised and directed stimulus for hex_undump against a queue-based reference model.
// The model and a per-cycle compare process run alongside hand-computed directed checks.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_hex_undump;

  localparam int DEPTH = 16;
  localparam int AB    = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  hex_undump_if #(.ADDR_BITS(AB)) bus();

  hex_undump #(.DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] mq[$];
  int         m_hi  = -1;
  bit         m_err = 1'b0;
  bit         m_ovf = 1'b0;
  int         m_k;
  bit         m_pop, m_push;
  logic [7:0] m_byte;

  // Returns 0..15 for hex digits, -2 for separators, -1 for anything else.
  function automatic int cls(logic [7:0] c);
    int v;
    v = int'(c);
    if (v >= 48 && v <= 57)  return v - 48;
    if (v >= 97 && v <= 102) return v - 97 + 10;
    if (v >= 65 && v <= 70)  return v - 65 + 10;
    if (v == 32 || v == 9 || v == 13 || v == 10) return -2;
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_hi  = -1;
      m_err = 1'b0;
      m_ovf = 1'b0;
    end else begin
      m_err  = 1'b0;
      m_push = 1'b0;
      m_byte = 8'h00;
      m_pop  = bus.out_read_strobe && (mq.size() > 0);
      if (bus.in_strobe) begin
        m_k = cls(bus.in_data);
        if (m_hi < 0) begin
          if (m_k >= 0)       m_hi = m_k;
          else if (m_k == -1) m_err = 1'b1;
        end else begin
          if (m_k >= 0) begin
            m_push = 1'b1;
            m_byte = 8'(m_hi * 16 + m_k);
          end else begin
            m_err = 1'b1;
          end
          m_hi = -1;
        end
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(m_byte);
        else                   m_ovf = 1'b1;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("avail", 32'(bus.out_available), 32'(mq.size() != 0));
      chk("data",  32'(bus.out_data),      (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      chk("count", 32'(bus.out_count),     32'(mq.size()));
      chk("err",   32'(bus.err_strobe),    32'(m_err));
      chk("ovf",   32'(bus.overflow),      32'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(bit s, logic [7:0] d, bit rd);
    @(negedge clk);
    bus.in_strobe       = s;
    bus.in_data         = d;
    bus.out_read_strobe = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_strobe       = 1'b0;
    bus.out_read_strobe = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  function automatic logic [7:0] hexch(logic [3:0] n, bit upper);
    string lo, up;
    lo = "0123456789abcdef";
    up = "0123456789ABCDEF";
    return upper ? up[n] : lo[n];
  endfunction

  function automatic logic [7:0] pat(int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  task automatic send_byte(logic [7:0] b, bit rd_on_second);
    cyc(1'b1, hexch(b[7:4], b[0]), 1'b0);
    cyc(1'b1, hexch(b[3:0], b[1]), rd_on_second);
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) cyc(1'b1, s[i], 1'b0);
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    string pool, seps;
    logic [7:0] c;
    int r;
    pool = "0123456789abcdefABCDEF";
    seps = " \t\r\n";
    bus.in_data = 8'h00;
    bus.in_strobe = 1'b0;
    bus.out_read_strobe = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    cmp_en = 1'b1;

    // Reset state
    cyc(1'b0, 8'h00, 1'b0);
    chk("rst_avail", 32'(bus.out_available), 32'h0);
    chk("rst_data",  32'(bus.out_data),      32'h0);
    chk("rst_ovf",   32'(bus.overflow),      32'h0);

    // Test 1: "4A"
    cyc(1'b1, "4", 1'b0);
    cyc(1'b1, "A", 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t1_avail", 32'(bus.out_available), 32'h1);
    chk("t1_data",  32'(bus.out_data),      32'h4A);
    chk("t1_count", 32'(bus.out_count),     32'h1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t1_avail_after", 32'(bus.out_available), 32'h0);
    chk("t1_data_after",  32'(bus.out_data),      32'h0);

    // Test 2: "de AD\r\n"
    send_str("de AD\r\n");
    cyc(1'b0, 8'h00, 1'b0);
    chk("t2_count", 32'(bus.out_count), 32'h2);
    chk("t2_head",  32'(bus.out_data),  32'hDE);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t2_second", 32'(bus.out_data), 32'hAD);
    drain(1);

    // Test 3: dangling nibble then "41"
    cyc(1'b1, "4", 1'b0);
    cyc(1'b1, " ", 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t3_err",   32'(bus.err_strobe), 32'h1);
    chk("t3_count", 32'(bus.out_count),  32'h0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t3_err_gone", 32'(bus.err_strobe), 32'h0);
    send_str("41");
    cyc(1'b0, 8'h00, 1'b0);
    chk("t3_data",  32'(bus.out_data),  32'h41);
    chk("t3_count1", 32'(bus.out_count), 32'h1);
    drain(1);

    // Test 4: bad char in EMPTY then "7f"
    cyc(1'b1, "G", 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t4_err",   32'(bus.err_strobe), 32'h1);
    chk("t4_count", 32'(bus.out_count),  32'h0);
    send_str("7f");
    cyc(1'b0, 8'h00, 1'b0);
    chk("t4_data", 32'(bus.out_data), 32'h7F);
    drain(1);

    // Test 5a: 17 pairs with no reads -> overflow, first 16 kept
    do_reset();
    for (int i = 0; i < 17; i++) send_byte(pat(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t5_count", 32'(bus.out_count), 32'd16);
    chk("t5_ovf",   32'(bus.overflow),  32'h1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("t5_drain", 32'(bus.out_data), 32'(pat(i)));
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("t5_empty", 32'(bus.out_available), 32'h0);

    // Test 5b: full FIFO, push completing together with a read
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(pat(i), 1'b0);
    send_byte(8'hC3, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t5b_count", 32'(bus.out_count), 32'd16);
    chk("t5b_ovf",   32'(bus.overflow),  32'h0);
    chk("t5b_head",  32'(bus.out_data),  32'(pat(1)));

    // Test 6: reset mid-stream
    do_reset();
    cyc(1'b1, "4", 1'b0);
    do_reset();
    chk("t6_avail", 32'(bus.out_available), 32'h0);
    chk("t6_err",   32'(bus.err_strobe),    32'h0);
    send_str("1A");
    cyc(1'b0, 8'h00, 1'b0);
    chk("t6_data", 32'(bus.out_data),   32'h1A);
    chk("t6_err2", 32'(bus.err_strobe), 32'h0);
    drain(1);

    // Randomised traffic: fill-heavy first half, drain-heavy second half
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      c = pool[$urandom_range(0, pool.len() - 1)];
      else if (r < 8) c = seps[$urandom_range(0, 3)];
      else            c = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        cyc(($urandom_range(0, 9) < 7),
            c,
            (n < 2000) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6));
      end
    end
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
